ebus_diag_xfer: RTL and testbench
=================================

Name: ebus_diag_xfer

Overview:
- Front-end EBUS diagnostic transfer sequencer; sits directly upstream of the CPU-side EBUS data mux.
- Accepts one diagnostic function request at a time. Drives EBUS data-select (DS) and the diag strobe with fixed setup/strobe/hold timing.
- For read functions, samples the muxed EBUS data and the per-board driver-select vector, and returns data plus driver-conflict status.
- For write functions, drives write data onto EBUS for the whole transfer.

Parameters:
- SETUP_CYC, 2, cycles DS (and write data) are stable before strobe asserts; minimum 1
- STROBE_CYC, 4, cycles diag strobe is asserted; minimum 1
- HOLD_CYC, 1, cycles DS/data stay stable after strobe drops; minimum 1
- NDRV, 30, number of EBUS driver boards reporting a driving flag

Ports:
- clk  in  1  system clock
- crobar  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_func  in  7  diag function code; bit 6 = 1 means read, 0 means write
- req_wdata  in  36  write data; ignored for reads
- ebus_ds  out  7  diag function / data select to all boards
- ebus_diag_strobe  out  1  diag strobe
- ebus_data_out  out  36  data driven onto EBUS for writes
- ebus_data_oe  out  1  front end driving EBUS data
- ebus_data_in  in  36  muxed EBUS data
- drv_driving  in  NDRV  one flag per board, set when that board drives EBUS
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_data  out  36  read data (write: echo of wdata)
- rsp_conflict  out  1  more than one driver at sample
- rsp_nodrv  out  1  no driver at sample
- busy  out  1  transfer in progress (state is not IDLE)

Behaviour:
- Reset, asynchronous: state = IDLE. All outputs are 0 except req_ready = 1. A strobe in progress drops immediately when crobar asserts, with no hold phase.
- States and transitions:
  - IDLE -> SETUP on req_valid && req_ready. At this edge, latch func, wdata and the read/write bit.
  - SETUP -> STROBE after SETUP_CYC cycles.
  - STROBE -> HOLD after STROBE_CYC cycles.
  - HOLD -> DONE after HOLD_CYC cycles.
  - DONE -> IDLE on rsp_ready (rsp_valid && rsp_ready).
- Cycle counting uses a down-counter reloaded on each state entry. Each phase lasts exactly its parameter count.
- req_ready = 1 only in IDLE.
- busy = 1 in SETUP, STROBE, HOLD and DONE.
- ebus_ds = latched func in SETUP, STROBE and HOLD; 0 in IDLE and DONE.
- ebus_diag_strobe = 1 only in STROBE, and is registered (glitch-free).
- For writes, ebus_data_oe = 1 and ebus_data_out = latched wdata in SETUP, STROBE and HOLD. Otherwise ebus_data_oe = 0 and ebus_data_out = 0.
- For reads, ebus_data_oe stays 0 throughout.
- Read sample: taken at the clock edge ending the last STROBE cycle.
  - rsp_data <= ebus_data_in.
  - Let n = popcount(drv_driving).
  - n > 1: rsp_conflict <= 1; data captured as-is.
  - n == 0: rsp_nodrv <= 1; rsp_data forced to 0.
- Write response: rsp_data = wdata, rsp_conflict = 0, rsp_nodrv = 0.
- rsp_valid = 1 only in DONE.
  - rsp_data, rsp_conflict and rsp_nodrv are held stable while rsp_valid = 1.
  - All three clear to 0 when returning to IDLE.
- Latency: with request accepted at edge k, rsp_valid is first high in the cycle after edge k + SETUP_CYC + STROBE_CYC + HOLD_CYC. With default parameters that is edge k+7, i.e. cycle 8.
- Back-to-back: rsp_ready in DONE returns to IDLE. The next request is accepted one cycle later at the earliest, so there is no overlap of transfers.
- req_valid while busy is ignored, since req_ready = 0; the request is not lost if the requester holds it.
- Input changes on req_func or req_wdata after acceptance have no effect.

Test Plan:
- Read, func 7'o100, default params; single driver with drv_driving = 1<<5 and ebus_data_in = 36'o123456_701234 -> strobe high for exactly 4 cycles, 2 setup cycles after ds = 7'o100; rsp_valid 8 cycles after accept; rsp_data = 36'o123456701234; conflict = 0, nodrv = 0.
- Write, func 7'o042, wdata = 36'o777000777000 -> ebus_data_oe = 1 and data stable for 7 cycles (setup, strobe, hold); rsp_data echoes wdata; oe drops at DONE.
- Read with drv_driving = 3 bits set -> rsp_conflict = 1, data as sampled. Read with drv_driving = 0 and ebus_data_in = all ones -> rsp_nodrv = 1, rsp_data = 0.
- Hold rsp_ready = 0 for 5 cycles in DONE -> rsp_valid and rsp_data stable, req_ready = 0. Then pulse rsp_ready -> IDLE, and a held req_valid is accepted on the next cycle.
- Assert crobar during STROBE -> ebus_diag_strobe, ebus_ds and oe drop before the next clock edge; after release req_ready = 1 and no rsp_valid is seen.
- Parameters SETUP_CYC = 1, STROBE_CYC = 1, HOLD_CYC = 1 -> rsp_valid 4 cycles after accept; strobe width 1 cycle.

Source files
------------

// File: rtl/ebus_diag_xfer.sv
`default_nettype none
// ============================================================================
// Module      : ebus_diag_xfer
// Description : EBUS diagnostic transfer sequencer (setup/strobe/hold timing,
//               read sampling with driver-conflict status, write drive).
// Revision    : 1.0
// ============================================================================
module ebus_diag_xfer #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1,
  parameter int NDRV       = 30
) (
  input  logic            clk,
  input  logic            crobar,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [6:0]      req_func,
  input  logic [35:0]     req_wdata,
  output logic [6:0]      ebus_ds,
  output logic            ebus_diag_strobe,
  output logic [35:0]     ebus_data_out,
  output logic            ebus_data_oe,
  input  logic [35:0]     ebus_data_in,
  input  logic [NDRV-1:0] drv_driving,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [35:0]     rsp_data,
  output logic            rsp_conflict,
  output logic            rsp_nodrv,
  output logic            busy
);

  localparam int c_MAXC = (SETUP_CYC > STROBE_CYC) ?
                          ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                          ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int c_CW = (c_MAXC > 1) ? $clog2(c_MAXC) : 1;
  localparam logic [c_CW-1:0] c_SETUP_LD  = c_CW'(SETUP_CYC - 1);
  localparam logic [c_CW-1:0] c_STROBE_LD = c_CW'(STROBE_CYC - 1);
  localparam logic [c_CW-1:0] c_HOLD_LD   = c_CW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [c_CW-1:0] r_cnt, w_cnt_nxt;
  logic [6:0]      r_func;
  logic [35:0]     r_wdata;
  logic            r_rd;
  logic            r_strobe;
  logic [35:0]     r_rsp_data;
  logic            r_conflict;
  logic            r_nodrv;
  logic            w_drive_phase;
  logic            w_last_strobe;
  logic            w_nodrv;
  logic            w_multi;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_nodrv       = ~|drv_driving;
  assign w_multi       = |(drv_driving & (drv_driving - NDRV'(1)));
  assign w_last_strobe = (r_state == S_STROBE) && (r_cnt == '0);
  assign w_drive_phase = (r_state == S_SETUP) || (r_state == S_STROBE) ||
                         (r_state == S_HOLD);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = c_SETUP_LD;
        end
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_STROBE;
          w_cnt_nxt   = c_STROBE_LD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_STROBE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = c_HOLD_LD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_DONE: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge crobar) begin
    if (crobar) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_func     <= '0;
      r_wdata    <= '0;
      r_rd       <= 1'b0;
      r_strobe   <= 1'b0;
      r_rsp_data <= '0;
      r_conflict <= 1'b0;
      r_nodrv    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_strobe <= (w_state_nxt == S_STROBE);
      if (r_state == S_IDLE && req_valid) begin
        r_func  <= req_func;
        r_wdata <= req_wdata;
        r_rd    <= req_func[6];
      end
      if (w_last_strobe) begin
        if (r_rd) begin
          r_rsp_data <= w_nodrv ? 36'd0 : ebus_data_in;
          r_conflict <= w_multi;
          r_nodrv    <= w_nodrv;
        end else begin
          r_rsp_data <= r_wdata;
          r_conflict <= 1'b0;
          r_nodrv    <= 1'b0;
        end
      end else if (r_state == S_DONE && rsp_ready) begin
        r_rsp_data <= '0;
        r_conflict <= 1'b0;
        r_nodrv    <= 1'b0;
      end
    end
  end

  assign req_ready        = (r_state == S_IDLE);
  assign busy             = (r_state != S_IDLE);
  assign ebus_ds          = w_drive_phase ? r_func : 7'd0;
  assign ebus_diag_strobe = r_strobe;
  assign ebus_data_oe     = w_drive_phase && !r_rd;
  assign ebus_data_out    = (w_drive_phase && !r_rd) ? r_wdata : 36'd0;
  // Response is only exposed while it is being offered.
  assign rsp_valid        = (r_state == S_DONE);
  assign rsp_data         = rsp_valid ? r_rsp_data : 36'd0;
  assign rsp_conflict     = rsp_valid && r_conflict;
  assign rsp_nodrv        = rsp_valid && r_nodrv;

endmodule
`default_nettype wire

// File: tb/tb_ebus_diag_xfer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ebus_diag_xfer
// Description : Randomised bench for ebus_diag_xfer against a transaction model.
// Revision    : 1.0
// ============================================================================
module tb_ebus_diag_xfer;

  localparam int c_SC = 2;
  localparam int c_TC = 4;
  localparam int c_HC = 1;
  localparam int c_N  = 40;

  logic        clk = 1'b0;
  logic        crobar;
  logic        req_valid, req_valid1;
  logic [6:0]  req_func;
  logic [35:0] req_wdata;
  logic [35:0] ebus_data_in;
  logic [29:0] drv_driving;
  logic        rsp_ready, rsp_ready1;

  logic        req_ready, ebus_diag_strobe, ebus_data_oe, rsp_valid, rsp_conflict, rsp_nodrv, busy;
  logic [6:0]  ebus_ds;
  logic [35:0] ebus_data_out, rsp_data;
  logic        req_ready1, ebus_diag_strobe1, ebus_data_oe1, rsp_valid1, rsp_conflict1, rsp_nodrv1, busy1;
  logic [6:0]  ebus_ds1;
  logic [35:0] ebus_data_out1, rsp_data1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ebus_diag_xfer dut (
    .clk(clk), .crobar(crobar), .req_valid(req_valid), .req_ready(req_ready),
    .req_func(req_func), .req_wdata(req_wdata), .ebus_ds(ebus_ds),
    .ebus_diag_strobe(ebus_diag_strobe), .ebus_data_out(ebus_data_out),
    .ebus_data_oe(ebus_data_oe), .ebus_data_in(ebus_data_in),
    .drv_driving(drv_driving), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_conflict(rsp_conflict), .rsp_nodrv(rsp_nodrv),
    .busy(busy)
  );

  ebus_diag_xfer #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .NDRV(30)) dut1 (
    .clk(clk), .crobar(crobar), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_func(req_func), .req_wdata(req_wdata), .ebus_ds(ebus_ds1),
    .ebus_diag_strobe(ebus_diag_strobe1), .ebus_data_out(ebus_data_out1),
    .ebus_data_oe(ebus_data_oe1), .ebus_data_in(ebus_data_in),
    .drv_driving(drv_driving), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_data(rsp_data1), .rsp_conflict(rsp_conflict1), .rsp_nodrv(rsp_nodrv1),
    .busy(busy1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected response {conflict, nodrv, data} from the transfer's rules.
  function automatic logic [37:0] model_rsp(input logic [6:0] func, input logic [35:0] wdata,
                                            input logic [35:0] din, input logic [29:0] drv);
    int n;
    n = $countones(drv);
    if (!func[6]) return {2'b00, wdata};
    return {(n > 1), (n == 0), ((n == 0) ? 36'd0 : din)};
  endfunction

  // Entered and left on a falling edge; nreq pre-presents the next request during DONE.
  task automatic xfer(input logic [6:0] func, input logic [35:0] wdata, input logic [35:0] din,
                      input logic [29:0] drv, input int hold, input logic nreq,
                      input logic [6:0] nfunc, input logic [35:0] nwdata);
    logic [37:0] exp;
    int lat, nstb, nset, nds, noe;
    bit seen_stb;
    exp = model_rsp(func, wdata, din, drv);
    lat = 0; nstb = 0; nset = 0; nds = 0; noe = 0; seen_stb = 0;
    req_valid = 1'b1; req_func = func; req_wdata = wdata;
    ebus_data_in = din; drv_driving = drv; rsp_ready = 1'b0;
    check("req_ready_idle", req_ready, 1);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      lat = i;
      if (i == 1) begin
        req_valid = 1'b0;
        req_func  = 7'($urandom);
        req_wdata = 36'({$urandom, $urandom});
        check("busy_after_accept", busy, 1);
      end
      if (rsp_valid) break;
      if (ebus_diag_strobe) begin
        nstb++;
        seen_stb = 1;
      end
      if (!seen_stb && ebus_ds === func) nset++;
      if (ebus_ds === func) nds++;
      if (ebus_data_oe && ebus_data_out === wdata) noe++;
      if (seen_stb && !ebus_diag_strobe) begin
        ebus_data_in = 36'({$urandom, $urandom});
        drv_driving  = 30'($urandom);
      end
    end
    check("latency", lat, c_SC + c_TC + c_HC + 1);
    check("strobe_width", nstb, c_TC);
    check("setup_cycles", nset, c_SC);
    check("ds_window", nds, c_SC + c_TC + c_HC);
    check("oe_window", noe, func[6] ? 0 : c_SC + c_TC + c_HC);
    check("rsp_data", rsp_data, exp[35:0]);
    check("rsp_conflict", rsp_conflict, exp[37]);
    check("rsp_nodrv", rsp_nodrv, exp[36]);
    check("done_outputs", {req_ready, ebus_diag_strobe, ebus_data_oe, ebus_ds}, 0);
    for (int k = 0; k < hold; k++) begin
      ebus_data_in = 36'({$urandom, $urandom});
      drv_driving  = 30'($urandom);
      req_valid = nreq; req_func = nfunc; req_wdata = nwdata;
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_data", {rsp_conflict, rsp_nodrv, rsp_data}, exp);
      check("hold_req_ready", req_ready, 0);
    end
    req_valid = nreq; req_func = nfunc; req_wdata = nwdata;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("idle_after_rsp", {req_ready, busy, rsp_valid}, 3'b100);
    check("rsp_cleared", {rsp_conflict, rsp_nodrv, rsp_data}, 0);
  endtask

  task automatic xfer1(input logic [6:0] func, input logic [35:0] wdata, input logic [35:0] din,
                       input logic [29:0] drv);
    logic [37:0] exp;
    int lat, nstb;
    exp = model_rsp(func, wdata, din, drv);
    lat = 0; nstb = 0;
    req_valid1 = 1'b1; req_func = func; req_wdata = wdata;
    ebus_data_in = din; drv_driving = drv;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      lat = i;
      req_valid1 = 1'b0;
      if (rsp_valid1) break;
      if (ebus_diag_strobe1) nstb++;
    end
    check("p1_latency", lat, 4);
    check("p1_strobe_width", nstb, 1);
    check("p1_rsp", {rsp_conflict1, rsp_nodrv1, rsp_data1}, exp);
    rsp_ready1 = 1'b1;
    @(negedge clk);
    rsp_ready1 = 1'b0;
    check("p1_idle", {req_ready1, rsp_valid1}, 2'b10);
  endtask

  logic [6:0]  t_func [c_N];
  logic [35:0] t_wdata[c_N];
  logic [35:0] t_din  [c_N];
  logic [29:0] t_drv  [c_N];
  int          t_hold [c_N];

  initial begin
    bit found, seen;
    crobar = 1'b1; req_valid = 1'b0; req_valid1 = 1'b0; rsp_ready = 1'b0; rsp_ready1 = 1'b0;
    req_func = '0; req_wdata = '0; ebus_data_in = '0; drv_driving = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_outputs", {busy, rsp_valid, ebus_diag_strobe, ebus_data_oe, ebus_ds}, 0);
    check("rst_data", {ebus_data_out, rsp_data, rsp_conflict, rsp_nodrv}, 0);
    crobar = 1'b0;
    @(negedge clk);

    for (int i = 0; i < c_N; i++) begin
      int mode;
      mode = $urandom_range(0, 2);
      t_func[i]  = 7'($urandom);
      t_wdata[i] = 36'({$urandom, $urandom});
      t_din[i]   = 36'({$urandom, $urandom});
      t_drv[i]   = (mode == 0) ? 30'd0 : (mode == 1) ? (30'd1 << $urandom_range(0, 29))
                                                     : 30'($urandom);
      t_hold[i]  = $urandom_range(0, 3);
    end
    t_func[0] = 7'o100; t_din[0] = 36'o123456701234; t_drv[0] = 30'd1 << 5; t_hold[0] = 0;
    t_func[1] = 7'o042; t_wdata[1] = 36'o777000777000; t_hold[1] = 5;
    t_func[2] = 7'o155; t_drv[2] = 30'h0000_0015; t_hold[2] = 1;
    t_func[3] = 7'o101; t_drv[3] = 30'd0; t_din[3] = '1; t_hold[3] = 2;

    for (int i = 0; i < c_N; i++) begin
      if (i + 1 < c_N)
        xfer(t_func[i], t_wdata[i], t_din[i], t_drv[i], t_hold[i], (i % 2 == 1),
             t_func[i+1], t_wdata[i+1]);
      else
        xfer(t_func[i], t_wdata[i], t_din[i], t_drv[i], t_hold[i], 1'b0, 7'd0, 36'd0);
    end

    // Reset in the middle of a write strobe.
    req_valid = 1'b1; req_func = 7'o042; req_wdata = 36'o252525252525;
    @(negedge clk);
    req_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (ebus_diag_strobe) found = 1;
      else @(negedge clk);
    end
    check("rst_reach_strobe", found, 1);
    @(negedge clk);
    #2 crobar = 1'b1;
    #1;
    check("rst_strobe_drop", {ebus_diag_strobe, ebus_data_oe, ebus_ds}, 0);
    check("rst_idle", {req_ready, busy}, 2'b10);
    @(negedge clk);
    crobar = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    check("rst_no_rsp", seen, 0);
    check("rst_release_ready", req_ready, 1);

    for (int i = 0; i < 4; i++)
      xfer1(t_func[i], t_wdata[i], t_din[i], t_drv[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
